// File: rtl/ram_access_ctrl_pkg.sv
// Shared encodings for the byte-serial RAM access controller: access lengths,
// controller states and the length/alignment helpers used at grant time.
package ram_access_ctrl_pkg;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;
    localparam int         RW_WRITE = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } ctrl_state_t;

    // Index of the final byte of an access (0, 1 or 3).
    function automatic logic [1:0] last_byte_idx(input logic [1:0] len);
        case (len)
            LEN_HALF: last_byte_idx = 2'd1;
            LEN_WORD: last_byte_idx = 2'd3;
            default:  last_byte_idx = 2'd0;
        endcase
    endfunction

    // Illegal length code or a half/word access that is not naturally aligned.
    function automatic logic len_addr_fault(input logic [1:0] len, input logic [1:0] addr_lo);
        case (len)
            LEN_BYTE: len_addr_fault = 1'b0;
            LEN_HALF: len_addr_fault = addr_lo[0];
            LEN_WORD: len_addr_fault = |addr_lo;
            default:  len_addr_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; requester 0 wins the first contention after reset.
// Latency: combinational grant while en=1; pointer updates on the granting edge.
// Backpressure: a losing request is simply not granted and stays pending upstream.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;  // index of the most recently granted requester

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (gnt[0]) begin
            last <= 1'b0;
        end else if (gnt[1]) begin
            last <= 1'b1;
        end
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Arbitrates fetch and load/store access to a byte-wide RAM, serialising 1/2/4-byte accesses.
// Latency from grant edge: fault 1, write N+1, read N+2 cycles to the one-cycle ack pulse.
// Backpressure: requests are held until ack; the loser of arbitration waits in place.
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic                 i_ack,
    output logic [31:0]          i_rdata,
    output logic                 i_exc,
    input  logic                 d_req,
    input  logic [2:0]           d_rw_len,
    input  logic [31:0]          d_addr,
    input  logic [31:0]          d_wdata,
    output logic                 d_ack,
    output logic [31:0]          d_rdata,
    output logic                 d_exc,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [RAM_WIDTH-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata
);

    ctrl_state_t          state;
    logic [1:0]           gnt;
    logic [RAM_WIDTH-1:0] lat_addr;
    logic [31:0]          lat_wdata;
    logic                 lat_write;
    logic                 lat_port_d;
    logic                 lat_exc;
    logic [1:0]           cnt;
    logic [1:0]           last_idx;
    logic [31:0]          asm_data;

    logic                 sel_write;
    logic                 sel_fault;
    logic [1:0]           sel_len;
    logic [31:0]          sel_addr;
    logic [31:0]          sel_wdata;
    logic [1:0]           nxt_idx;
    logic [1:0]           prev_idx;
    logic [RAM_WIDTH-1:0] nxt_addr;
    logic [7:0]           nxt_wdata;

    // Bit 0 is the data port so it wins the first contention after reset.
    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == IDLE),
        .req   ({i_req, d_req}),
        .gnt   (gnt)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_len   = LEN_WORD;
        sel_addr  = i_addr;
        sel_wdata = '0;
        if (gnt[0]) begin
            sel_write = d_rw_len[RW_WRITE];
            sel_len   = d_rw_len[1:0];
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end
        sel_fault = (|sel_addr[31:RAM_WIDTH]) || len_addr_fault(sel_len, sel_addr[1:0]);
    end

    assign nxt_idx   = cnt + 2'd1;
    assign prev_idx  = cnt - 2'd1;
    assign nxt_addr  = lat_addr + RAM_WIDTH'(nxt_idx);
    assign nxt_wdata = lat_wdata[{nxt_idx, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_write  <= 1'b0;
            lat_port_d <= 1'b0;
            lat_exc    <= 1'b0;
            cnt        <= 2'd0;
            last_idx   <= 2'd0;
            asm_data   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_ack      <= 1'b0;
            i_rdata    <= '0;
            i_exc      <= 1'b0;
            d_ack      <= 1'b0;
            d_rdata    <= '0;
            d_exc      <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            i_ack   <= 1'b0;
            i_rdata <= '0;
            i_exc   <= 1'b0;
            d_ack   <= 1'b0;
            d_rdata <= '0;
            d_exc   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        lat_port_d <= gnt[0];
                        lat_write  <= sel_write;
                        lat_addr   <= sel_addr[RAM_WIDTH-1:0];
                        lat_wdata  <= sel_wdata;
                        last_idx   <= last_byte_idx(sel_len);
                        cnt        <= 2'd0;
                        asm_data   <= '0;
                        lat_exc    <= sel_fault;
                        if (sel_fault) begin
                            state <= ACK;
                        end else begin
                            state     <= ISSUE;
                            mem_en    <= 1'b1;
                            mem_we    <= sel_write;
                            mem_addr  <= sel_addr[RAM_WIDTH-1:0];
                            mem_wdata <= sel_wdata[7:0];
                        end
                    end
                end
                ISSUE: begin
                    // RAM read data trails the issued byte by one cycle.
                    if (!lat_write && cnt != 2'd0) begin
                        asm_data[{prev_idx, 3'b000} +: 8] <= mem_rdata;
                    end
                    if (cnt == last_idx) begin
                        state <= lat_write ? ACK : WAIT;
                    end else begin
                        cnt       <= nxt_idx;
                        mem_en    <= 1'b1;
                        mem_we    <= lat_write;
                        mem_addr  <= nxt_addr;
                        mem_wdata <= nxt_wdata;
                    end
                end
                WAIT: begin
                    asm_data[{cnt, 3'b000} +: 8] <= mem_rdata;
                    state <= ACK;
                end
                ACK: begin
                    if (lat_port_d) begin
                        d_ack   <= 1'b1;
                        d_rdata <= asm_data;
                        d_exc   <= lat_exc;
                    end else begin
                        i_ack   <= 1'b1;
                        i_rdata <= asm_data;
                        i_exc   <= lat_exc;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
